// File: rtl/spi_pkg.sv
// Shared definitions for the SPI transaction arbiter: FSM encoding and
// default byte/timeout values used by the top and its bench.
package spi_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_GRANT   = 3'd1,
    S_SEND    = 3'd2,
    S_WAIT_RX = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  localparam logic [7:0] DUMMY_BYTE_DEF = 8'h00;
  localparam int         TIMEOUT_DEF    = 1024;

  // Bits needed to index n items; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_txn_arbiter_if.sv
// Requester handshake plus SPI_master-facing signals of the arbiter.
// The slave modport is the arbiter's view; master is the environment's view.
interface spi_txn_arbiter_if #(
  parameter int N_REQ    = 2,
  parameter int SPI_SIZE = 2,
  parameter int LEN_W    = 3
);
  logic [N_REQ-1:0]       req_valid;
  logic [8*N_REQ-1:0]     req_cmd;
  logic [LEN_W*N_REQ-1:0] req_len;
  logic [N_REQ-1:0]       req_ready;
  logic [N_REQ-1:0]       rsp_valid;
  logic [7:0]             rsp_data;
  logic                   rsp_last;
  logic                   rsp_err;
  logic                   busy;
  logic [7:0]             spi_tx_byte;
  logic                   spi_tx_dv;
  logic [SPI_SIZE-1:0]    spi_code;
  logic                   spi_tx_ready;
  logic                   spi_rx_dv;
  logic [7:0]             spi_rx_byte;

  modport slave (
    input  req_valid, req_cmd, req_len, spi_tx_ready, spi_rx_dv, spi_rx_byte,
    output req_ready, rsp_valid, rsp_data, rsp_last, rsp_err, busy,
           spi_tx_byte, spi_tx_dv, spi_code
  );

  modport master (
    output req_valid, req_cmd, req_len, spi_tx_ready, spi_rx_dv, spi_rx_byte,
    input  req_ready, rsp_valid, rsp_data, rsp_last, rsp_err, busy,
           spi_tx_byte, spi_tx_dv, spi_code
  );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request after the last-grant
// pointer, wrapping modulo N_REQ.
module rr_arbiter #(
  parameter int N_REQ = 2,
  parameter int IDX_W = 1
) (
  input  logic [IDX_W-1:0] ptr_i,
  input  logic [N_REQ-1:0] req_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0] idx_o
);

  logic             found;
  logic [IDX_W-1:0] j;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    j     = '0;
    // Offset N_REQ wraps back to the pointer itself, so the last owner is
    // only picked again when nobody else is waiting.
    for (int k = 1; k <= N_REQ; k++) begin
      j = IDX_W'((int'(ptr_i) + k) % N_REQ);
      if (!found && req_i[j]) begin
        found    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = j;
      end
    end
  end

endmodule

// File: rtl/spi_txn_arbiter.sv
// Round-robin transaction scheduler sharing one SPI_master among N_REQ
// requesters: command byte, len dummy bytes, read data back, watchdog abort.
module spi_txn_arbiter
  import spi_pkg::*;
#(
  parameter int         N_REQ      = 2,
  parameter int         SPI_SIZE   = 2,
  parameter int         LEN_W      = 3,
  parameter int         TIMEOUT    = TIMEOUT_DEF,
  parameter logic [7:0] DUMMY_BYTE = DUMMY_BYTE_DEF
) (
  input  logic             clk,
  input  logic             rst,
  spi_txn_arbiter_if.slave bus
);

  localparam int IDX_W = idx_width(N_REQ);
  localparam int WD_W  = idx_width(TIMEOUT);

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [IDX_W-1:0]    owner_q, owner_d;
  logic [7:0]          cmd_q, cmd_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [LEN_W-1:0]    cnt_q, cnt_d;
  logic [WD_W-1:0]     wd_q, wd_d;
  logic [SPI_SIZE-1:0] code_q, code_d;

  logic [N_REQ-1:0]    win_gnt;
  logic [IDX_W-1:0]    win_idx;
  logic [N_REQ-1:0]    owner_oh;
  logic                cnt_last;
  logic                wd_zero;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .ptr_i (ptr_q),
    .req_i (bus.req_valid),
    .gnt_o (win_gnt),
    .idx_o (win_idx)
  );

  assign owner_oh = N_REQ'(1) << owner_q;
  assign cnt_last = (cnt_q == len_q);
  assign wd_zero  = (wd_q == '0);

  // Pointer starts at the last requester so requester 0 wins first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= IDX_W'(N_REQ - 1);
      owner_q <= '0;
      cnt_q   <= '0;
      wd_q    <= '0;
      code_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      wd_q    <= wd_d;
      code_q  <= code_d;
    end
  end

  always_ff @(posedge clk) begin
    cmd_q <= cmd_d;
    len_q <= len_d;
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    cmd_d   = cmd_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    wd_d    = wd_q;
    code_d  = code_q;
    unique case (state_q)
      S_IDLE: begin
        if (|bus.req_valid) state_d = S_GRANT;
      end
      S_GRANT: begin
        if (|win_gnt) begin
          owner_d = win_idx;
          cmd_d   = bus.req_cmd[int'(win_idx)*8 +: 8];
          len_d   = bus.req_len[int'(win_idx)*LEN_W +: LEN_W];
          code_d  = SPI_SIZE'(win_idx);
          cnt_d   = '0;
          state_d = S_SEND;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SEND: begin
        if (bus.spi_tx_ready) begin
          wd_d    = WD_W'(TIMEOUT - 1);
          state_d = S_WAIT_RX;
        end
      end
      S_WAIT_RX: begin
        // Received data beats a watchdog expiring in the same cycle.
        if (bus.spi_rx_dv) begin
          if (cnt_last) begin
            state_d = S_DONE;
          end else begin
            cnt_d   = cnt_q + 1'b1;
            state_d = S_SEND;
          end
        end else if (wd_zero) begin
          state_d = S_DONE;
        end else begin
          wd_d = wd_q - 1'b1;
        end
      end
      S_DONE: begin
        ptr_d   = owner_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready   = '0;
    bus.rsp_valid   = '0;
    bus.rsp_data    = '0;
    bus.rsp_last    = 1'b0;
    bus.rsp_err     = 1'b0;
    bus.spi_tx_dv   = 1'b0;
    bus.spi_tx_byte = '0;
    bus.busy        = (state_q != S_IDLE);
    bus.spi_code    = code_q;
    unique case (state_q)
      S_GRANT: bus.req_ready = win_gnt;
      S_SEND: begin
        if (bus.spi_tx_ready) begin
          bus.spi_tx_dv   = 1'b1;
          bus.spi_tx_byte = (cnt_q == '0) ? cmd_q : DUMMY_BYTE;
        end
      end
      S_WAIT_RX: begin
        // The byte clocked in during the command exchange carries no data.
        if (bus.spi_rx_dv) begin
          if (cnt_q != '0) begin
            bus.rsp_valid = owner_oh;
            bus.rsp_data  = bus.spi_rx_byte;
            bus.rsp_last  = cnt_last;
          end
        end else if (wd_zero) begin
          bus.rsp_valid = owner_oh;
          bus.rsp_last  = 1'b1;
          bus.rsp_err   = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// Scoreboard bench for spi_txn_arbiter: directed requests against a small
// SPI_master model, with grant/tx/rsp expectations queued and popped by a monitor.
module tb_spi_txn_arbiter;

  typedef struct packed { logic [7:0] cmd; logic [2:0] len; } req_t;
  typedef struct packed { logic [1:0] vld; logic [7:0] data; logic last; logic err; } rsp_t;
  typedef struct packed { logic [1:0] code; logic [7:0] b; } tx_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;

  req_t       rq0[$];
  req_t       rq1[$];
  rsp_t       exp_rsp[$];
  tx_t        exp_tx[$];
  logic [1:0] exp_gnt[$];
  logic [7:0] rx_q[$];

  logic silent = 1'b0;
  logic bp_hold = 1'b0;
  logic model_rdy = 1'b1;
  int   tx_cnt = 0;
  int   rsp_cnt = 0;
  int   t_tx = 0;
  int   t_rsp = 0;

  spi_txn_arbiter_if #(.N_REQ(2), .SPI_SIZE(2), .LEN_W(3)) bus ();

  spi_txn_arbiter #(
    .N_REQ(2), .SPI_SIZE(2), .LEN_W(3), .TIMEOUT(16), .DUMMY_BYTE(8'h00)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  assign bus.spi_tx_ready = model_rdy & ~bp_hold;

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1, "global timeout");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  task automatic push_req(input int i, input logic [7:0] c, input logic [2:0] l);
    req_t r;
    r.cmd = c;
    r.len = l;
    if (i == 0) rq0.push_back(r); else rq1.push_back(r);
  endtask

  task automatic exp_t(input logic [1:0] code, input logic [7:0] b);
    tx_t t;
    t.code = code;
    t.b    = b;
    exp_tx.push_back(t);
  endtask

  task automatic exp_r(input logic [1:0] v, input logic [7:0] d, input logic l, input logic e);
    rsp_t r;
    r.vld  = v;
    r.data = d;
    r.last = l;
    r.err  = e;
    exp_rsp.push_back(r);
  endtask

  task automatic wait_done(input string nm, input int maxc);
    int c;
    c = 0;
    while (c < maxc && !(bus.busy == 1'b0 && rq0.size() == 0 && rq1.size() == 0 &&
                         exp_tx.size() == 0 && exp_rsp.size() == 0 && exp_gnt.size() == 0)) begin
      @(negedge clk);
      c++;
    end
    n_vec++;
    if (c >= maxc) begin
      n_err++;
      $display("FAIL %s_complete: still busy after %0d cycles, required idle", nm, c);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_tx(input string nm, input int c0, input int maxc);
    int c;
    c = 0;
    while (c < maxc && tx_cnt == c0) begin
      @(negedge clk);
      c++;
    end
    n_vec++;
    if (c >= maxc) begin
      n_err++;
      $display("FAIL %s_tx: no spi_tx_dv within %0d cycles, required one", nm, maxc);
    end
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_req_ready"}, 32'(bus.req_ready), 0);
    chk({nm, "_rsp"}, {21'd0, bus.rsp_valid, bus.rsp_data, bus.rsp_last}, 0);
    chk({nm, "_rsp_err_busy"}, {30'd0, bus.rsp_err, bus.busy}, 0);
    chk({nm, "_spi_tx"}, {23'd0, bus.spi_tx_dv, bus.spi_tx_byte}, 0);
    chk({nm, "_spi_code"}, 32'(bus.spi_code), 0);
  endtask

  // Requester drivers: present queue heads, pop on the accept pulse.
  initial begin
    logic [1:0] rdy;
    bus.req_valid = '0;
    bus.req_cmd   = '0;
    bus.req_len   = '0;
    forever begin
      @(negedge clk);
      rdy = bus.req_ready;
      @(posedge clk);
      #1;
      if (rdy[0] && rq0.size() > 0) void'(rq0.pop_front());
      if (rdy[1] && rq1.size() > 0) void'(rq1.pop_front());
      bus.req_valid[0] = (rq0.size() > 0);
      bus.req_valid[1] = (rq1.size() > 0);
      if (rq0.size() > 0) begin
        bus.req_cmd[7:0] = rq0[0].cmd;
        bus.req_len[2:0] = rq0[0].len;
      end
      if (rq1.size() > 0) begin
        bus.req_cmd[15:8] = rq1[0].cmd;
        bus.req_len[5:3]  = rq1[0].len;
      end
    end
  end

  // SPI_master model: ready drops after each byte; the received byte returns two cycles later.
  initial begin
    bus.spi_rx_dv   = 1'b0;
    bus.spi_rx_byte = 8'h00;
    forever begin
      @(negedge clk);
      if (bus.spi_tx_dv && !silent) begin
        @(posedge clk);
        #1;
        model_rdy = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        bus.spi_rx_byte = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hEE;
        bus.spi_rx_dv   = 1'b1;
        model_rdy       = 1'b1;
        @(posedge clk);
        #1;
        bus.spi_rx_dv = 1'b0;
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents an event.
  initial begin
    tx_t        et;
    rsp_t       er;
    rsp_t       ar;
    logic [1:0] eg;
    logic       prev_rdy_any;
    logic       prev_rst;
    logic [1:0] prev_code;
    prev_rdy_any = 1'b0;
    prev_rst     = 1'b1;
    prev_code    = '0;
    forever begin
      @(negedge clk);
      if (bus.spi_tx_dv) begin
        tx_cnt++;
        t_tx = cyc;
        if (exp_tx.size() == 0) begin
          chk("tx_unexpected", {22'd0, bus.spi_code, bus.spi_tx_byte}, 32'hFFFF_FFFF);
        end else begin
          et = exp_tx.pop_front();
          chk("tx_code_byte", {22'd0, bus.spi_code, bus.spi_tx_byte}, {22'd0, et});
        end
      end
      if (|bus.rsp_valid) begin
        rsp_cnt++;
        t_rsp = cyc;
        ar = {bus.rsp_valid, bus.rsp_data, bus.rsp_last, bus.rsp_err};
        if (exp_rsp.size() == 0) begin
          chk("rsp_unexpected", {20'd0, ar}, 32'hFFFF_FFFF);
        end else begin
          er = exp_rsp.pop_front();
          chk("rsp_vld_data_last_err", {20'd0, ar}, {20'd0, er});
        end
      end
      if (|bus.req_ready) begin
        if (exp_gnt.size() == 0) begin
          chk("gnt_unexpected", 32'(bus.req_ready), 32'hFFFF_FFFF);
        end else begin
          eg = exp_gnt.pop_front();
          chk("gnt_order", 32'(bus.req_ready), 32'(eg));
        end
      end
      if (!rst && !prev_rst && bus.spi_code != prev_code)
        chk("code_changes_after_grant", 32'(prev_rdy_any), 1);
      prev_rdy_any = |bus.req_ready;
      prev_rst     = rst;
      prev_code    = bus.spi_code;
    end
  end

  initial begin
    int c0;
    int r0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Contention: both requesters, each re-requesting once.
    rx_q = '{8'hE0, 8'hB0, 8'hE1, 8'hB1, 8'hE2, 8'hB2, 8'hE3, 8'hB3};
    exp_gnt = '{2'b01, 2'b10, 2'b01, 2'b10};
    exp_t(0, 8'h10); exp_t(0, 8'h00); exp_t(1, 8'h20); exp_t(1, 8'h00);
    exp_t(0, 8'h11); exp_t(0, 8'h00); exp_t(1, 8'h21); exp_t(1, 8'h00);
    exp_r(2'b01, 8'hB0, 1, 0); exp_r(2'b10, 8'hB1, 1, 0);
    exp_r(2'b01, 8'hB2, 1, 0); exp_r(2'b10, 8'hB3, 1, 0);
    push_req(0, 8'h10, 1); push_req(0, 8'h11, 1);
    push_req(1, 8'h20, 1); push_req(1, 8'h21, 1);
    wait_done("contention", 400);

    // Single request, len 2.
    rx_q = '{8'h11, 8'h22, 8'h33};
    exp_gnt.push_back(2'b01);
    exp_t(0, 8'hA5); exp_t(0, 8'h00); exp_t(0, 8'h00);
    exp_r(2'b01, 8'h22, 0, 0); exp_r(2'b01, 8'h33, 1, 0);
    push_req(0, 8'hA5, 2);
    wait_done("single_len2", 200);

    // len 0: one exchange, no response.
    c0 = tx_cnt;
    r0 = rsp_cnt;
    rx_q.push_back(8'h77);
    exp_gnt.push_back(2'b10);
    exp_t(1, 8'h3C);
    push_req(1, 8'h3C, 0);
    wait_tx("len0", c0, 50);
    chk("len0_busy_high", 32'(bus.busy), 1);
    wait_done("len0", 100);
    chk("len0_tx_count", 32'(tx_cnt - c0), 1);
    chk("len0_rsp_count", 32'(rsp_cnt - r0), 0);
    chk("len0_busy_low", 32'(bus.busy), 0);

    // Watchdog abort: model stays silent after the command.
    silent = 1'b1;
    exp_gnt.push_back(2'b01);
    exp_t(0, 8'h5A);
    exp_r(2'b01, 8'h00, 1, 1);
    push_req(0, 8'h5A, 3);
    wait_done("timeout", 200);
    chk("timeout_latency", 32'(t_rsp - t_tx), 16);
    @(posedge clk);
    #1;
    silent = 1'b0;

    // Ready backpressure: no byte and no watchdog abort while ready is low.
    bp_hold = 1'b1;
    c0 = tx_cnt;
    r0 = rsp_cnt;
    rx_q = '{8'hD0, 8'hD1};
    exp_gnt.push_back(2'b10);
    exp_t(1, 8'hC3); exp_t(1, 8'h00);
    exp_r(2'b10, 8'hD1, 1, 0);
    push_req(1, 8'hC3, 1);
    repeat (50) @(negedge clk);
    chk("bp_no_tx", 32'(tx_cnt - c0), 0);
    chk("bp_no_rsp", 32'(rsp_cnt - r0), 0);
    chk("bp_busy", 32'(bus.busy), 1);
    @(posedge clk);
    #1;
    bp_hold = 1'b0;
    wait_done("backpressure", 200);

    // Leave the pointer at requester 0, then kill a requester-1 transaction.
    rx_q.push_back(8'h55);
    exp_gnt.push_back(2'b01);
    exp_t(0, 8'h4B);
    push_req(0, 8'h4B, 0);
    wait_done("pre_reset", 100);
    silent = 1'b1;
    c0 = tx_cnt;
    r0 = rsp_cnt;
    exp_gnt.push_back(2'b10);
    exp_t(1, 8'h99);
    push_req(1, 8'h99, 2);
    wait_tx("reset_mid", c0, 50);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk_all_zero("reset_mid");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    silent = 1'b0;
    chk("reset_mid_no_rsp", 32'(rsp_cnt - r0), 0);
    rx_q = '{8'h61, 8'h62};
    exp_gnt = '{2'b01, 2'b10};
    exp_t(0, 8'h01); exp_t(1, 8'h02);
    push_req(0, 8'h01, 0);
    push_req(1, 8'h02, 0);
    wait_done("after_reset", 200);

    chk("end_exp_tx_left", 32'(exp_tx.size()), 0);
    chk("end_exp_rsp_left", 32'(exp_rsp.size()), 0);
    chk("end_exp_gnt_left", 32'(exp_gnt.size()), 0);
    chk("end_rx_bytes_left", 32'(rx_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
